// File: rtl/pdpu_pkg.sv
// Shared PDPU types: shift direction, default-width shift request and index helpers.
package pdpu_pkg;

  localparam int unsigned PDPU_WIDTH       = 27;
  localparam int unsigned PDPU_SHIFT_WIDTH = 5;
  localparam int unsigned PDPU_NUM_REQ     = 4;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  typedef struct packed {
    logic [PDPU_WIDTH-1:0]       operand;
    logic [PDPU_SHIFT_WIDTH-1:0] shamt;
    shift_dir_e                  dir;
  } shift_req_t;

  // Successor of idx in a ring of n entries.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Logarithmic logical barrel shifter; MODE 0 shifts left, MODE 1 shifts right, zero fill.
module barrel_shifter #(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned MODE        = 0
) (
  input  logic [WIDTH-1:0]       operand,
  input  logic [SHIFT_WIDTH-1:0] shamt,
  output logic [WIDTH-1:0]       result
);

  logic [WIDTH-1:0] stage [SHIFT_WIDTH+1];

  assign stage[0] = operand;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    localparam int unsigned Dist = 2 ** k;
    if (Dist >= WIDTH) begin : g_flush
      // Any set bit at or beyond WIDTH empties the word.
      assign stage[k+1] = shamt[k] ? '0 : stage[k];
    end else if (MODE == 0) begin : g_left
      assign stage[k+1] = shamt[k] ? {stage[k][WIDTH-1-Dist:0], {Dist{1'b0}}} : stage[k];
    end else begin : g_right
      assign stage[k+1] = shamt[k] ? {{Dist{1'b0}}, stage[k][WIDTH-1:Dist]} : stage[k];
    end
  end

  assign result = stage[SHIFT_WIDTH];

endmodule

// File: rtl/pdpu_rr_arbiter.sv
// Request arbiter: round-robin with PDPU_SHIFT_ARB_RR_EN defined, lowest-index-wins otherwise.
module pdpu_rr_arbiter
  import pdpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] winner;
  logic            found;
  int unsigned     base;
  int unsigned     cand;

`ifdef PDPU_SHIFT_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  assign base = 32'(ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ID_W'(next_index(32'(winner), NUM_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_ctrl;

  assign base        = 32'd0;
  assign unused_ctrl = ^{clk, rst_n, advance};
`endif

  // Scan from the highest-priority index; the first valid requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 32'd0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (base + i) % NUM_REQ;
      if (!found && valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (enable && found) begin
      grant[winner] = 1'b1;
    end
  end

  assign grant_idx = winner;

endmodule

// File: rtl/pdpu_shift_arbiter.sv
// Shared barrel-shift datapath arbitrated among NUM_REQ requesters with a registered,
// backpressured result stage. PDPU_SHIFT_ARB_RR_EN selects round-robin arbitration.
module pdpu_shift_arbiter
  import pdpu_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]       req_operand_i,
  input  logic [NUM_REQ*SHIFT_WIDTH-1:0] req_shamt_i,
  input  logic [NUM_REQ-1:0]             req_dir_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [WIDTH-1:0]               rsp_result_o,
  output logic [ID_W-1:0]                rsp_id_o
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [WIDTH-1:0]       result_q;
  logic [ID_W-1:0]        id_q;

  logic                   can_accept;
  logic                   arb_enable;
  logic                   accept;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic [WIDTH-1:0]       operand_sel;
  logic [SHIFT_WIDTH-1:0] shamt_sel;
  shift_dir_e             dir_sel;
  logic [WIDTH-1:0]       left_result;
  logic [WIDTH-1:0]       right_result;
  logic [WIDTH-1:0]       shifted;

  assign rsp_valid_o = (state_q == ST_FULL);
  assign can_accept  = !rsp_valid_o || rsp_ready_i;
  // Gating with the reset keeps ready low while the reset is held.
  assign arb_enable  = can_accept && rst_ni;
  assign accept      = |grant;
  assign req_ready_o = grant;

  pdpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .valid     (req_valid_i),
    .enable    (arb_enable),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    operand_sel = '0;
    shamt_sel   = '0;
    dir_sel     = SHIFT_LEFT;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        operand_sel = req_operand_i[i*WIDTH +: WIDTH];
        shamt_sel   = req_shamt_i[i*SHIFT_WIDTH +: SHIFT_WIDTH];
        dir_sel     = shift_dir_e'(req_dir_i[i]);
      end
    end
  end

  barrel_shifter #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .MODE        (0)
  ) u_shift_left (
    .operand (operand_sel),
    .shamt   (shamt_sel),
    .result  (left_result)
  );

  barrel_shifter #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .MODE        (1)
  ) u_shift_right (
    .operand (operand_sel),
    .shamt   (shamt_sel),
    .result  (right_result)
  );

  assign shifted = (dir_sel == SHIFT_RIGHT) ? right_result : left_result;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // A new accept implies rsp_ready_i, so a refill keeps the stage full.
        if (rsp_ready_i && !accept) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_EMPTY;
      result_q <= '0;
      id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        result_q <= shifted;
        id_q     <= grant_idx;
      end
    end
  end

  assign rsp_result_o = result_q;
  assign rsp_id_o     = id_q;

endmodule

// File: tb/tb_pdpu_shift_arbiter.sv
// Self-checking bench for pdpu_shift_arbiter (WIDTH=8, SHIFT_WIDTH=3, NUM_REQ=4).
module tb_pdpu_shift_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_operand;
  logic [N*SW-1:0] req_shamt;
  logic [N-1:0]    req_dir;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_result;
  logic [IW-1:0]   rsp_id;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  result;
  } rsp_t;

  rsp_t        sb[$];
  int unsigned ptr_m = 0;

  rsp_t        mon_exp;
  rsp_t        mon_got;
  logic [N-1:0] mon_ready;
  logic        mon_full;
  logic        mon_found;
  int unsigned mon_g;
  int unsigned mon_cand;

  pdpu_shift_arbiter #(
    .NUM_REQ     (N),
    .WIDTH       (W),
    .SHIFT_WIDTH (SW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_operand_i (req_operand),
    .req_shamt_i   (req_shamt),
    .req_dir_i     (req_dir),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_result_o  (rsp_result),
    .rsp_id_o      (rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] shift_m(input logic [W-1:0] op, input logic [SW-1:0] sh,
                                           input logic dir);
    return dir ? (op >> sh) : (op << sh);
  endfunction

  // Scoreboard: expectation pushed when the model sees an accept, popped on a drain.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      ptr_m = 0;
      n_checks++;
      if (req_ready !== '0) $display("FAIL ready_in_reset: got %b want 0000", req_ready);
      else n_pass++;
    end else begin
      mon_full = (sb.size() != 0);
      n_checks++;
      if (rsp_valid !== mon_full) $display("FAIL rsp_valid: got %b want %b", rsp_valid, mon_full);
      else n_pass++;
      if (mon_full && rsp_ready) begin
        mon_exp = sb.pop_front();
        mon_got = {rsp_id, rsp_result};
        n_checks++;
        if (mon_got !== mon_exp)
          $display("FAIL drain: got id %0d result %h want id %0d result %h",
                   rsp_id, rsp_result, mon_exp.id, mon_exp.result);
        else n_pass++;
      end
      mon_ready = '0;
      mon_found = 1'b0;
      mon_g     = 0;
      if (!mon_full || rsp_ready) begin
        for (int i = 0; i < N; i++) begin
          mon_cand = (ptr_m + i) % N;
          if (!mon_found && req_valid[mon_cand]) begin
            mon_found = 1'b1;
            mon_g     = mon_cand;
          end
        end
        if (mon_found) begin
          mon_ready[mon_g] = 1'b1;
          sb.push_back({mon_g[IW-1:0], shift_m(req_operand[mon_g*W +: W],
                                               req_shamt[mon_g*SW +: SW], req_dir[mon_g])});
`ifdef PDPU_SHIFT_ARB_RR_EN
          ptr_m = (mon_g + 1) % N;
`endif
        end
      end
      n_checks++;
      if (req_ready !== mon_ready) $display("FAIL req_ready: got %b want %b", req_ready, mon_ready);
      else n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid   = '0;
    req_operand = '0;
    req_shamt   = '0;
    req_dir     = '0;
  endtask

  task automatic set_req(input int idx, input logic [W-1:0] op, input logic [SW-1:0] sh,
                         input logic dir);
    req_operand[idx*W +: W]  = op;
    req_shamt[idx*SW +: SW]  = sh;
    req_dir[idx]             = dir;
    req_valid[idx]           = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (2) tick();
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid);
    else n_pass++;
    n_checks++;
    if (rsp_result !== 8'h00) $display("FAIL reset_result: got %h want 00", rsp_result);
    else n_pass++;
    n_checks++;
    if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", rsp_id);
    else n_pass++;
    clear_reqs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_left();
    rsp_ready = 1'b1;
    set_req(0, 8'h81, 3'd1, 1'b0);
    tick();
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h02 || rsp_id !== 2'd0)
      $display("FAIL single_left: got v%b %h id%0d want v1 02 id0", rsp_valid, rsp_result, rsp_id);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_left_drain: got %b want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_right_shift();
    rsp_ready = 1'b1;
    set_req(2, 8'h80, 3'd7, 1'b1);
    tick();
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h01 || rsp_id !== 2'd2)
      $display("FAIL right_shift: got v%b %h id%0d want v1 01 id2", rsp_valid, rsp_result, rsp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_zero_shift();
    rsp_ready = 1'b1;
    set_req(1, 8'hA5, 3'd0, 1'b0);
    tick();
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'hA5 || rsp_id !== 2'd1)
      $display("FAIL zero_shift: got v%b %h id%0d want v1 a5 id1", rsp_valid, rsp_result, rsp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_ids[5];
`ifdef PDPU_SHIFT_ARB_RR_EN
    exp_ids = '{0, 1, 2, 3, 0};
`else
    exp_ids = '{0, 0, 0, 0, 0};
`endif
    test_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 8'h13 << i, SW'(i + 1), i[0]);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_ids[k][IW-1:0])
        $display("FAIL round_robin[%0d]: got v%b id%0d want v1 id%0d", k, rsp_valid, rsp_id,
                 exp_ids[k]);
      else n_pass++;
      tick();
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(0, 8'h10, 3'd2, 1'b0);
    tick();
    clear_reqs();
    set_req(3, 8'h06, 3'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h40 || rsp_id !== 2'd0 || req_ready !== 4'b0000)
        $display("FAIL stall[%0d]: got v%b %h id%0d rdy%b want v1 40 id0 rdy0000", k, rsp_valid,
                 rsp_result, rsp_id, req_ready);
      else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL drain_ready: got %b want 1000", req_ready);
    else n_pass++;
    tick();
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h03 || rsp_id !== 2'd3)
      $display("FAIL no_bubble: got v%b %h id%0d want v1 03 id3", rsp_valid, rsp_result, rsp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_req(1, 8'h0F, 3'd4, 1'b0);
    tick();
    clear_reqs();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'hF0)
      $display("FAIL mid_hold: got v%b %h want v1 f0", rsp_valid, rsp_result);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 8'h00 || rsp_id !== 2'd0)
      $display("FAIL mid_reset: got v%b %h id%0d want v0 00 id0", rsp_valid, rsp_result, rsp_id);
    else n_pass++;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL mid_no_resp: got %b want 0", rsp_valid);
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_single_left();
    test_right_shift();
    test_zero_shift();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pdpu_shift_arbiter.md
# pdpu_shift_arbiter

Shares one left/right barrel-shift datapath among `NUM_REQ` requesters inside the PDPU (alignment, normalization and quire-extraction stages).
- Each requester presents an operand, a shift amount and a direction on a valid/ready handshake.
- The block grants one requester per cycle, performs the logical shift, and registers the result with the granted requester's index.
- The output stage has full valid/ready backpressure.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 27: operand/result bit-width.
- `SHIFT_WIDTH`, 5: shift-amount bit-width.
- `ID_W`, `$clog2(NUM_REQ)`: derived; requester-index width.

Ports:
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `req_valid_i` in `NUM_REQ`: request valid per requester.
- `req_ready_o` out `NUM_REQ`: request accepted this cycle (one-hot or zero).
- `req_operand_i` in `NUM_REQ×WIDTH`: operand per requester.
- `req_shamt_i` in `NUM_REQ×SHIFT_WIDTH`: shift amount per requester.
- `req_dir_i` in `NUM_REQ`: 0 = shift left, 1 = shift right.
- `rsp_valid_o` out 1: result register holds a valid result.
- `rsp_ready_i` in 1: downstream accepts result.
- `rsp_result_o` out `WIDTH`: shifted result.
- `rsp_id_o` out `ID_W`: index of the requester that produced the result.

## Operation
Output-register state machine:
- **EMPTY** (`rsp_valid_o`=0):
  - Any request valid → accept it → FULL.
- **FULL** (`rsp_valid_o`=1):
  - `rsp_ready_i`=1 and a request valid → accept it, stay FULL (back-to-back).
  - `rsp_ready_i`=1 and no request valid → EMPTY.
  - `rsp_ready_i`=0 → hold all outputs stable, accept nothing.

Accept condition:
- `can_accept = !rsp_valid_o || rsp_ready_i`.
- `req_ready_o[g]` = 1 only for the granted index g, and only when `can_accept` and `req_valid_i[g]`. All other bits are 0.
- `req_ready_o` depends on `req_valid_i` combinationally. Requesters must not make valid depend on ready.

Shift:
- Logical, zero-fill, computed combinationally from the granted request.
- Left shift: `operand << shamt`, bits shifted past the MSB are dropped.
- Right shift: `operand >> shamt`.
- `shamt` ≥ `WIDTH` → result 0.
- `shamt` = 0 → operand unchanged in either direction.

Grant:
- The arbiter considers only valid requesters.
- With no valid requester nothing is accepted and the priority pointer is unchanged.
- Priority pointer update rules are defined under Configuration.

Reset values, applied on a clock edge with `rst_ni`=0:
- `rsp_valid_o`=0, `rsp_result_o`=0, `rsp_id_o`=0, priority pointer = 0.
- `req_ready_o` is forced to all zeros while `rst_ni`=0.
- Reset mid-transfer discards the held result; no response is emitted for it.

## Timing
- Latency: request accepted in cycle N → `rsp_valid_o`=1 with its result in cycle N+1.
- Throughput: one result per cycle while `rsp_ready_i` is held high.
- Stall: while `rsp_valid_o && !rsp_ready_i`, `rsp_result_o` and `rsp_id_o` stay bit-stable and no `req_ready_o` bit is asserted.
- Simultaneous drain and fill: the old result leaves and the new one is captured at the same edge, with no bubble.
- No combinational path from `rsp_ready_i` to `rsp_result_o`/`rsp_id_o`. A path from `rsp_ready_i` to `req_ready_o` is permitted.

## Configuration
Macro `PDPU_SHIFT_ARB_RR_EN`:
- **Defined:** round-robin arbitration.
  - The highest-priority index is the pointer.
  - After an accepted transfer from g, the pointer becomes (g+1) mod `NUM_REQ`, wrapping from `NUM_REQ-1` to 0.
  - The pointer updates only on an accepted transfer, not on stall.
- **Undefined:** fixed priority. The lowest valid index always wins, and no pointer register exists.

## Structure
- Shared package `pdpu_pkg`:
  - typedef `shift_dir_e` (`SHIFT_LEFT`=0, `SHIFT_RIGHT`=1).
  - typedef for the request struct (operand, shamt, dir), parameterised via package constants for the default widths.
- One natural sub-module, `pdpu_rr_arbiter`:
  - Takes `NUM_REQ` valid bits, an enable and an advance strobe.
  - Produces a one-hot grant and the grant index.
  - Holds the pointer under `PDPU_SHIFT_ARB_RR_EN`.
- The shift datapath is two `barrel_shifter` instances (MODE 0 and 1), with the output selected by the granted `req_dir_i`.

## Test plan
Bench parameters: `WIDTH`=8, `SHIFT_WIDTH`=3, `NUM_REQ`=4.
- **Reset:** `rst_ni`=0 for 2 cycles with all `req_valid_i`=1 → `req_ready_o`=0000, `rsp_valid_o`=0, `rsp_result_o`=0x00.
- **Single left shift:** req0 operand 0x81, shamt 1, dir 0 → next cycle `rsp_valid_o`=1, result 0x02, id 0.
- **Right shift:** req2 operand 0x80, shamt 7, dir 1 → result 0x01, id 2.
- **Zero shift:** req1 operand 0xA5, shamt 0, dir 0 → result 0xA5, id 1.
- **Round-robin (macro defined):** all four valid, `rsp_ready_i`=1 → ids 0,1,2,3,0 in consecutive cycles. With the macro undefined → ids 0,0,0,…
- **Backpressure:** `rsp_ready_i`=0 for 3 cycles with result 0x40 held → result and id stable, `req_ready_o`=0000. Then raise `rsp_ready_i` with req3 valid → 0x40 drains and req3's result appears at the next edge with no bubble.
